silife_grid_sequencer: RTL and testbench

Sequencer and arbiter for the shared write/step port of the 8x32 life grid (enable, row_select, set_cells, clear_cells). It sequences three competing users of that port: a whole-grid clear, a row-by-row pattern load from a host byte stream, and generation stepping, either free-running at a programmable period or single-stepped. It sits between the top-level I/O decoding and the grid instance. The grid's second read port, used by the display driver, is untouched.

---
 rtl/silife_grid_sequencer.sv | 149 ++++++++++++++
 tb/tb_silife_grid_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_grid_sequencer.sv
// Sequencer/arbiter for the shared write/step port of the life grid.
// It arbitrates between a whole-grid clear, a row-by-row pattern load, and
// generation stepping, which can be free-running or single-stepped.
// All grid-side outputs are registered. o_load_ready is decoded from state.
module silife_grid_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ROWS        = 32,
    parameter int unsigned ROW_BITS    = 5,
    parameter int unsigned PERIOD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic [PERIOD_BITS-1:0] i_period,
    input  logic                   i_clear,
    input  logic                   i_load_start,
    input  logic                   i_load_valid,
    input  logic [WIDTH-1:0]       i_load_data,
    output logic                   o_load_ready,
    output logic                   o_grid_enable,
    output logic [ROW_BITS-1:0]    o_row_select,
    output logic [WIDTH-1:0]       o_set_cells,
    output logic [WIDTH-1:0]       o_clear_cells,
    output logic                   o_busy,
    output logic [15:0]            o_gen_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ROW_BITS-1:0]    row_q;
    logic [PERIOD_BITS-1:0] period_cnt_q;
    logic [PERIOD_BITS-1:0] period_cnt_d;
    logic                   pending_q;
    logic                   pending_d;
    logic                   grid_enable_q;
    logic [ROW_BITS-1:0]    row_select_q;
    logic [WIDTH-1:0]       set_cells_q;
    logic [WIDTH-1:0]       clear_cells_q;
    logic                   busy_q;
    logic [15:0]            gen_count_q;

    logic [PERIOD_BITS-1:0] period_eff;
    logic [PERIOD_BITS-1:0] period_last;
    logic                   period_hit;
    logic                   gen_issue;
    logic                   row_last;

    // Period timer, generation issue decision and the pending request flag.
    always_comb begin
        period_eff   = (i_period == '0) ? PERIOD_BITS'(1) : i_period;
        period_last  = period_eff - PERIOD_BITS'(1);
        period_hit   = 1'b0;
        period_cnt_d = period_cnt_q;
        if (!i_run) begin
            period_cnt_d = '0;
        end else if (state_q == IDLE) begin
            // Use >= so that lowering the period mid-count still expires
            // promptly instead of running on until the counter wraps.
            if (period_cnt_q >= period_last) begin
                period_cnt_d = '0;
                period_hit   = 1'b1;
            end else begin
                period_cnt_d = period_cnt_q + PERIOD_BITS'(1);
            end
        end
        gen_issue = (state_q == IDLE) && !i_clear && !i_load_start && pending_q;
        // A new request in the same cycle as an issue re-arms pending.
        // This keeps a period-1 run issuing every cycle.
        pending_d = i_step | period_hit | (pending_q & ~gen_issue);
        row_last  = (row_q == ROW_BITS'(ROWS - 1));
    end

    // Main state machine and registered grid-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            period_cnt_q  <= '0;
            pending_q     <= 1'b0;
            grid_enable_q <= 1'b0;
            row_select_q  <= '0;
            set_cells_q   <= '0;
            clear_cells_q <= '0;
            busy_q        <= 1'b0;
            gen_count_q   <= '0;
        end else begin
            period_cnt_q  <= period_cnt_d;
            pending_q     <= pending_d;
            grid_enable_q <= gen_issue;
            row_select_q  <= '0;
            set_cells_q   <= '0;
            clear_cells_q <= '0;
            busy_q        <= (state_q != IDLE);
            if (gen_issue) begin
                gen_count_q <= gen_count_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (i_clear) begin
                        state_q <= CLEAR;
                        row_q   <= '0;
                    end else if (i_load_start) begin
                        state_q <= LOAD;
                        row_q   <= '0;
                    end
                end
                CLEAR: begin
                    row_select_q  <= row_q;
                    clear_cells_q <= '1;
                    row_q         <= row_q + ROW_BITS'(1);
                    if (row_last) begin
                        state_q     <= IDLE;
                        gen_count_q <= '0;
                    end
                end
                LOAD: begin
                    // A restart takes precedence over a byte offered in the same cycle.
                    if (i_load_start) begin
                        row_q <= '0;
                    end else if (i_load_valid) begin
                        row_select_q  <= row_q;
                        set_cells_q   <= i_load_data;
                        clear_cells_q <= ~i_load_data;
                        row_q         <= row_q + ROW_BITS'(1);
                        if (row_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_load_ready  = (state_q == LOAD);
    assign o_grid_enable = grid_enable_q;
    assign o_row_select  = row_select_q;
    assign o_set_cells   = set_cells_q;
    assign o_clear_cells = clear_cells_q;
    assign o_busy        = busy_q;
    assign o_gen_count   = gen_count_q;

endmodule

// File: tb/tb_silife_grid_sequencer.sv
// Self-checking bench for silife_grid_sequencer.
// Output bundle layout: {enable, row[4:0], set[7:0], clear[7:0], ready, busy, gen[15:0]}.
module tb_silife_grid_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_run = 1'b0;
    logic        i_step = 1'b0;
    logic [15:0] i_period = 16'd4;
    logic        i_clear = 1'b0;
    logic        i_load_start = 1'b0;
    logic        i_load_valid = 1'b0;
    logic [7:0]  i_load_data = 8'd0;
    logic        o_load_ready;
    logic        o_grid_enable;
    logic [4:0]  o_row_select;
    logic [7:0]  o_set_cells;
    logic [7:0]  o_clear_cells;
    logic        o_busy;
    logic [15:0] o_gen_count;

    int tests = 0;
    int fails = 0;

    silife_grid_sequencer #(
        .WIDTH(8), .ROWS(32), .ROW_BITS(5), .PERIOD_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_step(i_step), .i_period(i_period),
        .i_clear(i_clear), .i_load_start(i_load_start), .i_load_valid(i_load_valid),
        .i_load_data(i_load_data), .o_load_ready(o_load_ready), .o_grid_enable(o_grid_enable),
        .o_row_select(o_row_select), .o_set_cells(o_set_cells), .o_clear_cells(o_clear_cells),
        .o_busy(o_busy), .o_gen_count(o_gen_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, run, step, clr, ld;
        logic        en;
        logic [4:0]  row;
        logic [7:0]  set, clrc;
        logic        rdy, busy;
        logic [15:0] gen;
    } vec_t;

    vec_t vt[9];

    function automatic logic [39:0] mk(logic en, logic [4:0] row, logic [7:0] set,
                                       logic [7:0] clr, logic rdy, logic busy, logic [15:0] gen);
        return {en, row, set, clr, rdy, busy, gen};
    endfunction

    function automatic logic [39:0] dut_out();
        return {o_grid_enable, o_row_select, o_set_cells, o_clear_cells, o_load_ready, o_busy, o_gen_count};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference model: the mode is 0 idle, 1 clearing, 2 loading.
    int          m_mode = 0;
    int          m_row  = 0;
    int          m_cnt  = 0;
    int          m_gens = 0;
    bit          m_pend = 0;

    function automatic logic [39:0] model_step();
        logic       en = 1'b0;
        logic [4:0] row_o = '0;
        logic [7:0] set_o = '0;
        logic [7:0] clr_o = '0;
        logic       busy_o;
        bit         req;
        int         per;
        if (reset) begin
            m_mode = 0; m_row = 0; m_cnt = 0; m_gens = 0; m_pend = 0;
            return '0;
        end
        per    = (i_period == 16'd0) ? 1 : int'(i_period);
        busy_o = (m_mode != 0);
        req    = i_step;
        if (!i_run) m_cnt = 0;
        else if (m_mode == 0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt >= per) begin
                m_cnt = 0;
                req = 1;
            end
        end
        if (m_mode == 0) begin
            if (i_clear) begin m_mode = 1; m_row = 0; end
            else if (i_load_start) begin m_mode = 2; m_row = 0; end
            else if (m_pend) begin
                en = 1'b1;
                m_gens = (m_gens + 1) % 65536;
            end
        end else if (m_mode == 1) begin
            row_o = m_row[4:0];
            clr_o = 8'hFF;
            m_row = m_row + 1;
            if (m_row == 32) begin m_mode = 0; m_gens = 0; end
        end else begin
            if (i_load_start) m_row = 0;
            else if (i_load_valid) begin
                row_o = m_row[4:0];
                set_o = i_load_data;
                clr_o = ~i_load_data;
                m_row = m_row + 1;
                if (m_row == 32) m_mode = 0;
            end
        end
        m_pend = req || (m_pend && !en);
        return mk(en, row_o, set_o, clr_o, m_mode == 2, busy_o, m_gens[15:0]);
    endfunction

    initial begin
        logic [39:0] e;
        int          pulses;
        // rst run step clr ld | en row set clr rdy busy gen
        vt[0] = '{1,1,1,0,0, 0,5'd0,8'h00,8'h00,0,0,16'd0};
        vt[1] = '{1,1,1,0,0, 0,5'd0,8'h00,8'h00,0,0,16'd0};
        vt[2] = '{1,1,1,0,0, 0,5'd0,8'h00,8'h00,0,0,16'd0};
        vt[3] = '{0,0,1,0,0, 0,5'd0,8'h00,8'h00,0,0,16'd0};
        vt[4] = '{0,0,0,0,0, 1,5'd0,8'h00,8'h00,0,0,16'd1};
        vt[5] = '{0,0,0,0,0, 0,5'd0,8'h00,8'h00,0,0,16'd1};
        vt[6] = '{0,0,0,1,1, 0,5'd0,8'h00,8'h00,0,0,16'd1};
        vt[7] = '{0,0,0,0,0, 0,5'd0,8'h00,8'hFF,0,1,16'd1};
        vt[8] = '{0,0,0,0,0, 0,5'd1,8'h00,8'hFF,0,1,16'd1};

        // Reset with run/step, then a single step, then simultaneous clear and load start.
        for (int i = 0; i < 9; i++) begin
            reset = vt[i].rst; i_run = vt[i].run; i_step = vt[i].step;
            i_clear = vt[i].clr; i_load_start = vt[i].ld;
            cycle();
            check($sformatf("vec%0d", i), dut_out(),
                  mk(vt[i].en, vt[i].row, vt[i].set, vt[i].clrc, vt[i].rdy, vt[i].busy, vt[i].gen));
        end
        i_clear = 0; i_load_start = 0;

        // The rest of the clear sweep; the generation count drops to 0 on the last row.
        for (int i = 2; i < 32; i++) begin
            cycle();
            check($sformatf("clear_row%0d", i), dut_out(),
                  mk(0, 5'(i), 8'h00, 8'hFF, 0, 1, (i == 31) ? 16'd0 : 16'd1));
        end
        cycle();
        check("clear_done", dut_out(), '0);

        // Load 32 rows with a gap cycle after each byte, and two steps issued during the load.
        i_load_start = 1;
        cycle();
        check("load_start", dut_out(), mk(0, 0, 0, 0, 1, 0, 0));
        i_load_start = 0;
        for (int n = 0; n < 32; n++) begin
            i_load_valid = 1; i_load_data = 8'(n);
            cycle();
            check($sformatf("load_row%0d", n), dut_out(),
                  mk(0, 5'(n), 8'(n), ~8'(n), (n < 31), 1, 0));
            i_load_valid = 0;
            if (n < 31) begin
                i_step = (n == 5 || n == 20);
                cycle();
                check($sformatf("load_gap%0d", n), dut_out(), mk(0, 0, 0, 0, 1, 1, 0));
                i_step = 0;
            end
        end
        cycle();
        check("load_step_issue", dut_out(), mk(1, 0, 0, 0, 0, 0, 1));
        cycle();
        check("load_step_once", dut_out(), mk(0, 0, 0, 0, 0, 0, 1));

        // Free-running with period 4, then with period 0, which behaves as period 1.
        i_period = 16'd4; i_run = 1;
        for (int k = 1; k <= 22; k++) begin
            if (k == 21) i_run = 0;
            cycle();
            pulses = (k >= 5) ? (k - 1) / 4 : 0;
            check($sformatf("p4_k%0d", k), {o_grid_enable, o_gen_count},
                  {23'd0, (k >= 5 && (k - 1) % 4 == 0), 16'(1 + pulses)});
        end
        i_period = 16'd0; i_run = 1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check($sformatf("p0_k%0d", k), {o_grid_enable, o_gen_count},
                  {23'd0, (k >= 2), 16'(6 + ((k >= 2) ? k - 1 : 0))});
        end
        i_run = 0;
        cycle();
        check("p0_tail", {o_grid_enable, o_gen_count}, {23'd0, 1'b1, 16'd16});
        cycle();
        check("p0_stop", {o_grid_enable, o_gen_count}, {23'd0, 1'b0, 16'd16});
        i_period = 16'd4;

        // Assert reset while the load is at row 10.
        i_load_start = 1;
        cycle();
        check("rst_load_start", dut_out(), mk(0, 0, 0, 0, 1, 0, 16));
        i_load_start = 0;
        for (int n = 0; n < 10; n++) begin
            i_load_valid = 1; i_load_data = 8'(n * 7);
            cycle();
            check($sformatf("rst_load_row%0d", n), dut_out(),
                  mk(0, 5'(n), 8'(n * 7), ~8'(n * 7), 1, 1, 16));
        end
        reset = 1; i_load_data = 8'hA5;
        cycle();
        check("rst_mid_load", dut_out(), '0);
        reset = 0; i_load_valid = 0;
        cycle();
        check("rst_after", dut_out(), '0);

        // Randomised traffic checked against the reference model.
        reset = 1;
        e = model_step();
        cycle();
        check("rand_reset", dut_out(), e);
        reset = 0;
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            i_clear      = ($urandom_range(0, 79) == 0);
            i_load_start = ($urandom_range(0, 79) == 0);
            i_step       = ($urandom_range(0, 11) == 0);
            i_load_valid = ($urandom_range(0, 2) != 0) && !i_load_start;
            i_load_data  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                i_run    = ~i_run;
                i_period = 16'($urandom_range(0, 6));
            end
            e = model_step();
            cycle();
            check($sformatf("rand%0d", c), dut_out(), e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
